reg_file_bank: RTL and testbench
================================

Name: reg_file_bank

Overview:
- Parametrised successor to the single R/W register: a bank of 2**ADDR_W XLEN-bit registers with one byte-strobed write port and two combinational read ports.
- Supports an optional hardwired-zero entry 0 and a sequential soft-clear engine.
- Sits in the CORE as the integer register file, between decode (read addresses) and writeback (write port).

Parameters:
- XLEN, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 5, register address width; number of registers NREG = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wenble  input  1  write request.
- wstrb  input  XLEN/8  byte-lane write enables; bit i covers wdata[8i+7:8i].
- waddr  input  ADDR_W  write address.
- wdata  input  XLEN  write data.
- raddr1  input  ADDR_W  read port 1 address.
- rdata1  output  XLEN  read port 1 data.
- raddr2  input  ADDR_W  read port 2 address.
- rdata2  output  XLEN  read port 2 data.
- clr_req  input  1  soft-clear request, single-cycle pulse or level.
- busy  output  1  high while the soft clear is in progress.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: all NREG registers go to 0, FSM to IDLE, clear pointer to 0, busy to 0. rdata1/rdata2 then read 0 combinationally.
- Write acceptance:
  - A write is accepted at a rising edge when wenble=1, busy=0 and the address is not the protected entry. The address is protected when ZERO_REG=1 and waddr=0.
  - For an accepted write, each byte lane with wstrb[i]=1 takes wdata; lanes with wstrb[i]=0 hold their value.
  - wstrb=0 with wenble=1 changes nothing.
  - Writes while busy=1 are dropped silently.
- Reads: combinational, zero cycles.
  - rdataN = reg[raddrN], except 0 when ZERO_REG=1 and raddrN=0.
  - rdataN = 0 while busy=1, regardless of address.
  - Both ports may use the same address.
- Clear FSM states: IDLE and CLEAR.
  - IDLE: clr_req=1 at an edge moves to CLEAR with ptr=0 and busy=1 from the next cycle. A write arriving in the same cycle as clr_req is still accepted first, and then cleared.
  - CLEAR: each cycle writes 0 to reg[ptr] and increments ptr. At ptr=NREG-1 it writes 0, returns to IDLE and resets ptr to 0, with busy=0 from the next cycle.
  - A clear lasts exactly NREG cycles with busy high.
  - clr_req while in CLEAR is ignored; there is no restart.
  - ptr is ADDR_W bits wide; the terminal compare is against all-ones, so there is no wrap beyond NREG-1.
- rst_n asserted mid-clear: immediate return to IDLE, all registers 0, busy 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. When a write is being accepted this cycle, and raddrN=waddr, and the address is not the protected entry, then rdataN is the post-write value: wdata bytes on lanes where wstrb=1, stored bytes elsewhere. Same-cycle read and write is therefore seen with zero latency.
- Not defined: rdataN returns the pre-write stored value; the new value is visible from the cycle after the edge.
- No effect on any other behaviour, including while busy.

Decomposition:
- Shared header core_general.vh holds:
  - XLEN.
  - The FSM state encodings, as localparams REGF_ST_IDLE=1'b0 and REGF_ST_CLEAR=1'b1.
  - The REGFILE_BYPASS_EN macro definition point.
- One natural sub-module, reg_file_clr_ctrl, contains:
  - The IDLE/CLEAR FSM.
  - The ADDR_W-bit pointer.
  - Outputs busy, clr_we and clr_addr.
- The top level keeps the storage array, write merge, read muxes and bypass.

Test Plan:
- Reset then read: release rst_n, read raddr1=5, raddr2=31 -> rdata1=0, rdata2=0, busy=0.
- Byte-strobed write: write waddr=3, wdata=32'hAABBCCDD, wstrb=4'hF; then waddr=3, wdata=32'h11223344, wstrb=4'b0101; read raddr1=3 next cycle -> 32'hAA22CC44.
- Zero register: ZERO_REG=1, write waddr=0, wdata=32'hFFFFFFFF, wstrb=4'hF -> rdata1 at raddr1=0 stays 0. With ZERO_REG=0 the same stimulus reads 32'hFFFFFFFF.
- Soft clear:
  - Preload regs 1..31 with nonzero values, then pulse clr_req -> busy high for exactly 32 cycles and rdata forced 0.
  - A write to waddr=7 during busy is dropped.
  - After busy falls, all registers read 0.
  - A second clr_req mid-clear does not extend busy.
- Reset mid-clear: assert rst_n=0 at cycle 10 of CLEAR -> busy=0 asynchronously and all registers 0. A new clr_req after release gives a full 32-cycle clear.
- Bypass:
  - Reg 9 holds 32'h12345678; same-cycle write waddr=raddr1=9, wdata=32'hCAFEBABE, wstrb=4'b0011.
  - With REGFILE_BYPASS_EN: rdata1=32'h1234BABE that cycle.
  - Without REGFILE_BYPASS_EN: rdata1=32'h12345678 that cycle and 32'h1234BABE the next.

Source files
------------

// File: rtl/reg_file_bank_pkg.sv
// Shared constants for the integer register file: default data width and clear-FSM state encodings.
// The REGFILE_BYPASS_EN build macro is tested in reg_file_bank.sv; define it on the tool command line.
package reg_file_bank_pkg;

  localparam int REGF_XLEN = 32;

  localparam logic REGF_ST_IDLE  = 1'b0;
  localparam logic REGF_ST_CLEAR = 1'b1;

  typedef enum logic {
    ST_IDLE  = REGF_ST_IDLE,
    ST_CLEAR = REGF_ST_CLEAR
  } regf_state_e;

endpackage

// File: rtl/reg_file_bank_if.sv
// Write/read/clear bus of the register file; master is decode/writeback, slave is the bank.
interface reg_file_bank_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic                wenble;
  logic [XLEN/8-1:0]   wstrb;
  logic [ADDR_W-1:0]   waddr;
  logic [XLEN-1:0]     wdata;
  logic [ADDR_W-1:0]   raddr1;
  logic [XLEN-1:0]     rdata1;
  logic [ADDR_W-1:0]   raddr2;
  logic [XLEN-1:0]     rdata2;
  logic                clr_req;
  logic                busy;

  modport master (
    output wenble, wstrb, waddr, wdata, raddr1, raddr2, clr_req,
    input  rdata1, rdata2, busy
  );

  modport slave (
    input  wenble, wstrb, waddr, wdata, raddr1, raddr2, clr_req,
    output rdata1, rdata2, busy
  );
endinterface

// File: rtl/reg_file_clr_ctrl.sv
// Soft-clear sequencer: walks a pointer over every register, one zero-write per cycle, busy throughout.
module reg_file_clr_ctrl
  import reg_file_bank_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  regf_state_e       r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (clr_req) begin
        r_state <= ST_CLEAR;
        r_ptr   <= '0;
        r_busy  <= 1'b1;
      end
    end else begin
      // clr_req is deliberately not looked at here: a clear cannot be restarted
      if (r_ptr == {ADDR_W{1'b1}}) begin
        r_state <= ST_IDLE;
        r_ptr   <= '0;
        r_busy  <= 1'b0;
      end else begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  assign busy     = r_busy;
  assign clr_we   = r_busy;
  assign clr_addr = r_ptr;

endmodule

// File: rtl/reg_file_bank.sv
// Integer register file: 2**ADDR_W x XLEN, one byte-strobed write port, two combinational read ports.
// Build macro REGFILE_BYPASS_EN forwards a same-cycle accepted write to matching read ports.
module reg_file_bank
  import reg_file_bank_pkg::*;
#(
  parameter int XLEN     = REGF_XLEN,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_file_bank_if.slave  bus
);

  localparam int NREG  = 2**ADDR_W;
  localparam int NBYTE = XLEN / 8;

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_prot;
  logic              w_wr_acc;
  logic [XLEN-1:0]   w_wr_old;
  logic [XLEN-1:0]   w_wr_merged;
  logic [XLEN-1:0]   w_regs  [NREG];
  logic [ADDR_W-1:0] w_raddr [2];
  logic [XLEN-1:0]   w_rdata [2];

  reg_file_clr_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clr_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (bus.clr_req),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign w_wr_prot = (ZERO_REG != 0) && (bus.waddr == '0);
  assign w_wr_acc  = bus.wenble && !w_busy && !w_wr_prot;
  assign w_wr_old  = w_regs[bus.waddr];

  for (genvar gi = 0; gi < NBYTE; gi++) begin : g_lane
    assign w_wr_merged[8*gi +: 8] = bus.wstrb[gi] ? bus.wdata[8*gi +: 8] : w_wr_old[8*gi +: 8];
  end

  // Clear and write never collide: writes are only accepted while the clear engine is idle
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [XLEN-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (w_clr_we && (w_clr_addr == ADDR_W'(gi))) begin
        r_q <= '0;
      end else if (w_wr_acc && (bus.waddr == ADDR_W'(gi))) begin
        r_q <= w_wr_merged;
      end
    end

    assign w_regs[gi] = r_q;
  end

  assign w_raddr[0] = bus.raddr1;
  assign w_raddr[1] = bus.raddr2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rport
    logic [XLEN-1:0] w_rd;

    always_comb begin
      w_rd = w_regs[w_raddr[gi]];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_acc && (w_raddr[gi] == bus.waddr)) begin
        w_rd = w_wr_merged;
      end
`endif
      if (((ZERO_REG != 0) && (w_raddr[gi] == '0)) || w_busy) begin
        w_rd = '0;
      end
    end

    assign w_rdata[gi] = w_rd;
  end

  assign bus.rdata1 = w_rdata[0];
  assign bus.rdata2 = w_rdata[1];
  assign bus.busy   = w_busy;

endmodule

// File: tb/tb_reg_file_bank.sv
// Randomised and directed check of reg_file_bank (ZERO_REG=1 and ZERO_REG=0 copies) against an array model.
module tb_reg_file_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_file_bank_if #(.XLEN(32), .ADDR_W(5)) bus_z ();
  reg_file_bank_if #(.XLEN(32), .ADDR_W(5)) bus_nz ();

  assign bus_nz.wenble  = bus_z.wenble;
  assign bus_nz.wstrb   = bus_z.wstrb;
  assign bus_nz.waddr   = bus_z.waddr;
  assign bus_nz.wdata   = bus_z.wdata;
  assign bus_nz.raddr1  = bus_z.raddr1;
  assign bus_nz.raddr2  = bus_z.raddr2;
  assign bus_nz.clr_req = bus_z.clr_req;

  reg_file_bank #(.XLEN(32), .ADDR_W(5), .ZERO_REG(1)) dut_z (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_z)
  );

  reg_file_bank #(.XLEN(32), .ADDR_W(5), .ZERO_REG(0)) dut_nz (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nz)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: index 0 is the ZERO_REG=1 bank, index 1 the ZERO_REG=0 bank
  bit [31:0] m_mem [2][32];
  int        m_busy_left;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] wd, input bit [3:0] strb);
    bit [31:0] mask = 32'h0;
    for (int b = 0; b < 4; b++)
      if (strb[b]) mask |= (32'hFF << (8 * b));
    return (wd & mask) | (old & ~mask);
  endfunction

  function automatic bit accepted(input int k, input bit we, input bit [4:0] wa);
    return we && (m_busy_left == 0) && !(k == 0 && wa == 5'd0);
  endfunction

  function automatic bit [31:0] exp_read(input int k, input bit [4:0] ra, input bit we,
                                         input bit [3:0] strb, input bit [4:0] wa, input bit [31:0] wd);
    if (m_busy_left > 0) return 32'h0;
    if (k == 0 && ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (accepted(k, we, wa) && ra == wa) return merge(m_mem[k][wa], wd, strb);
`endif
    return m_mem[k][ra];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 32; a++) m_mem[k][a] = 32'h0;
    m_busy_left = 0;
  endtask

  // Called at a falling edge: apply inputs, check just before the rising edge, then advance the model
  task automatic tick(input bit we, input bit [3:0] strb, input bit [4:0] wa, input bit [31:0] wd,
                      input bit [4:0] ra1, input bit [4:0] ra2, input bit clr);
    bus_z.wenble  = we;
    bus_z.wstrb   = strb;
    bus_z.waddr   = wa;
    bus_z.wdata   = wd;
    bus_z.raddr1  = ra1;
    bus_z.raddr2  = ra2;
    bus_z.clr_req = clr;
    #4;
    check_eq("rd1_z",  bus_z.rdata1,  exp_read(0, ra1, we, strb, wa, wd));
    check_eq("rd2_z",  bus_z.rdata2,  exp_read(0, ra2, we, strb, wa, wd));
    check_eq("rd1_nz", bus_nz.rdata1, exp_read(1, ra1, we, strb, wa, wd));
    check_eq("rd2_nz", bus_nz.rdata2, exp_read(1, ra2, we, strb, wa, wd));
    check_eq("busy_z",  {31'b0, bus_z.busy},  {31'b0, m_busy_left > 0});
    check_eq("busy_nz", {31'b0, bus_nz.busy}, {31'b0, m_busy_left > 0});
    $display("t=%0t we=%0b strb=%h wa=%0d wd=%h ra1=%0d rd1=%h ra2=%0d rd2=%h clr=%0b busy=%0b",
             $time, we, strb, wa, wd, ra1, bus_z.rdata1, ra2, bus_z.rdata2, clr, bus_z.busy);
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      if (accepted(k, we, wa)) m_mem[k][wa] = merge(m_mem[k][wa], wd, strb);
    if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (clr) begin
      for (int k = 0; k < 2; k++)
        for (int a = 0; a < 32; a++) m_mem[k][a] = 32'h0;
      m_busy_left = 32;
    end
    @(negedge clk);
  endtask

  task automatic idle_read(input bit [4:0] ra1, input bit [4:0] ra2);
    tick(1'b0, 4'h0, 5'd0, 32'h0, ra1, ra2, 1'b0);
  endtask

  task automatic read_all();
    for (int a = 0; a < 32; a += 2) idle_read(5'(a), 5'(a + 1));
  endtask

  task automatic count_clear(input string tag, input bit poke);
    int n = 0;
    while (bus_z.busy && n < 100) begin
      tick(poke && n == 5, 4'hF, 5'd7, 32'hDEAD0007, 5'd7, 5'($urandom), poke && n == 10);
      n++;
    end
    check_eq(tag, 32'(n), 32'd32);
  endtask

  initial begin
    rst_n = 1'b0;
    bus_z.wenble = 1'b0; bus_z.wstrb = '0; bus_z.waddr = '0; bus_z.wdata = '0;
    bus_z.raddr1 = 5'd5; bus_z.raddr2 = 5'd31; bus_z.clr_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("busy_in_reset", {31'b0, bus_z.busy}, 32'h0);
    rst_n = 1'b1;

    idle_read(5'd5, 5'd31);

    // Byte-strobed merge
    tick(1'b1, 4'hF,    5'd3, 32'hAABBCCDD, 5'd1, 5'd2, 1'b0);
    tick(1'b1, 4'b0101, 5'd3, 32'h11223344, 5'd1, 5'd2, 1'b0);
    idle_read(5'd3, 5'd3);
    check_eq("strb_merge", bus_z.rdata1, 32'hAA22CC44);

    // Protected entry 0
    tick(1'b1, 4'hF, 5'd0, 32'hFFFFFFFF, 5'd1, 5'd2, 1'b0);
    idle_read(5'd0, 5'd0);
    check_eq("zero_reg_z",  bus_z.rdata1,  32'h0);
    check_eq("zero_reg_nz", bus_nz.rdata1, 32'hFFFFFFFF);

    // Same-cycle write/read on reg 9
    tick(1'b1, 4'hF,    5'd9, 32'h12345678, 5'd1, 5'd2, 1'b0);
    tick(1'b1, 4'b0011, 5'd9, 32'hCAFEBABE, 5'd9, 5'd9, 1'b0);
    idle_read(5'd9, 5'd3);
    check_eq("bypass_next", bus_z.rdata1, 32'h1234BABE);

    // Random traffic, occasional clears
    for (int i = 0; i < 300; i++) begin
      bit [4:0] wa = 5'($urandom);
      tick(1'($urandom), 4'($urandom), wa, $urandom,
           ($urandom_range(3) == 0) ? wa : 5'($urandom), 5'($urandom), $urandom_range(79) == 0);
    end
    while (bus_z.busy && m_busy_left > 0) idle_read(5'($urandom), 5'($urandom));

    // Soft clear with dropped write and ignored second request
    for (int a = 1; a < 32; a++) tick(1'b1, 4'hF, 5'(a), $urandom | 32'h1, 5'(a), 5'd0, 1'b0);
    tick(1'b0, 4'h0, 5'd0, 32'h0, 5'd4, 5'd5, 1'b1);
    count_clear("clear_len", 1'b1);
    read_all();
    idle_read(5'd7, 5'd31);
    check_eq("clr_reg7", bus_nz.rdata1, 32'h0);

    // Reset during a clear
    for (int a = 0; a < 32; a++) tick(1'b1, 4'hF, 5'(a), $urandom | 32'h100, 5'd1, 5'd2, 1'b0);
    tick(1'b0, 4'h0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b1);
    repeat (10) idle_read(5'd1, 5'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_busy_z",  {31'b0, bus_z.busy},  32'h0);
    check_eq("rst_mid_busy_nz", {31'b0, bus_nz.busy}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    read_all();
    tick(1'b0, 4'h0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b1);
    count_clear("clear_len_after_rst", 1'b0);
    read_all();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
